fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Owns the far side of the program counter's start/done handshake.
- Sequences each program run through load, run and done phases.
- Computes the next-PC value fed to the 12-bit PC register: sequential, branch-LUT target, or hold on halt.
- Keeps a run-cycle counter for the testbench.
- Sits between the decode stage, the testbench start/done pins and the PC register input.

Parameters:
- PC_W, 12, program counter width.
- LUT_IDX_W, 4, branch target LUT index width (depth = 2**LUT_IDX_W = 16).
- CYC_W, 16, run-cycle counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  testbench start; high = program load phase.
- done  output  1  registered; high = program finished.
- pc_cur  input  PC_W  current PC value (PC register output).
- pc_next  output  PC_W  next PC value (PC register input).
- branch_en  input  1  decoded instruction is a conditional branch.
- branch_taken  input  1  branch condition true this cycle.
- branch_idx  input  LUT_IDX_W  LUT entry selected by the branch.
- halt  input  1  decoded instruction is halt.
- lut_we  input  1  LUT write strobe (honoured only in LOAD).
- lut_waddr  input  LUT_IDX_W  LUT write index.
- lut_wdata  input  PC_W  LUT write data.
- cycle_count  output  CYC_W  RUN cycles in the current or last run.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, done=0, cycle_count=0.
  - All 16 LUT entries cleared to 0.
  - Reset mid-run aborts immediately, with no partial state kept.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: start=1 -> LOAD.
  - LOAD: start=1 -> stay; start=0 -> RUN. On LOAD entry, cycle_count<=0.
  - RUN: halt=1 -> DONE. start=1 -> LOAD (abort, done stays 0, cycle_count<=0).
  - DONE: done=1 registered and held; start=1 -> LOAD with done<=0 on the same edge.
- done timing: done rises on the clock edge that enters DONE, one cycle after halt is sampled in RUN.
- LUT writes: lut_we writes lut_wdata to entry lut_waddr at the clock edge, in LOAD only; ignored in other states.
- pc_next (combinational, priority order):
  - State not RUN: pc_next=pc_cur (the PC register holds while start or done is high anyway).
  - RUN and halt: pc_next=pc_cur. Halt beats branch if both are asserted.
  - RUN and branch_en and branch_taken: pc_next=lut[branch_idx].
  - Otherwise: pc_next=pc_cur+1 modulo 2**PC_W; 4095 wraps to 0 with no flag.
  - branch_en with branch_taken=0 is sequential.
- cycle_count:
  - Increments every RUN cycle, including the halt cycle.
  - Saturates at 2**CYC_W-1.
  - Holds in DONE; cleared on LOAD entry.
- Latency: pc_next has zero-cycle latency from pc_cur and the decode inputs; done and cycle_count are registered.

Optional Feature:
- Macro: FETCH_BRANCH_REL_EN.
- Defined: LUT entries are signed two's-complement PC_W offsets; taken branch gives pc_next=pc_cur+lut[branch_idx] modulo 2**PC_W.
- Not defined: LUT entries are absolute targets, as above.
- Reset value (0) and write rules are identical in both cases.

Decomposition:
- Shared package fetch_pkg:
  - PC_W, LUT_IDX_W and CYC_W constants.
  - typedef pc_t (logic [PC_W-1:0]).
  - enum fetch_state_t {IDLE, LOAD, RUN, DONE}.
- One natural sub-module, branch_lut: 16 x PC_W register file with LOAD-gated write, async-clear reset and combinational read.
- The FSM, next-PC mux and counter stay in fetch_ctrl.

Test Plan:
- Reset low mid-RUN with cycle_count=37 -> done=0, cycle_count=0 and lut[3]=0 immediately, without waiting for a clock edge.
- start=1 for 3 cycles, write lut[5]=0x2A0, release start; pc_cur=0x010, branch_en=1, branch_taken=1, branch_idx=5 -> pc_next=0x2A0. With FETCH_BRANCH_REL_EN defined, writing lut[5]=0xFF0 (-16) gives pc_next=0x000.
- RUN, pc_cur=0xFFF, no branch -> pc_next=0x000. Same cycle with branch_taken=0 and branch_en=1 -> still 0x000.
- RUN for 9 cycles, halt and branch_taken asserted together on the 10th -> pc_next=pc_cur that cycle; done=1 next edge; cycle_count=10 and held while in DONE.
- In DONE, assert start -> done=0 on that edge, cycle_count=0. lut_we pulsed while in DONE (before start) -> LUT unchanged.
- In RUN, assert start for 1 cycle -> state LOAD, done stays 0, counter cleared; release start -> RUN resumes counting from 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, types and FSM encoding for the fetch controller
package fetch_pkg;
    localparam int PC_W      = 12;
    localparam int LUT_IDX_W = 4;
    localparam int CYC_W     = 16;
    localparam int LUT_DEPTH = 1 << LUT_IDX_W;

    typedef logic [PC_W-1:0]      pc_t;
    typedef logic [LUT_IDX_W-1:0] lut_idx_t;
    typedef logic [CYC_W-1:0]     cyc_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - start/done handshake, decode, LUT write and next-PC bundle
interface fetch_if;
    import fetch_pkg::*;

    logic     start;
    logic     done;
    pc_t      pc_cur;
    pc_t      pc_next;
    logic     branch_en;
    logic     branch_taken;
    lut_idx_t branch_idx;
    logic     halt;
    logic     lut_we;
    lut_idx_t lut_waddr;
    pc_t      lut_wdata;
    cyc_t     cycle_count;

    modport master (
        output start, pc_cur, branch_en, branch_taken, branch_idx, halt,
               lut_we, lut_waddr, lut_wdata,
        input  done, pc_next, cycle_count
    );

    modport slave (
        input  start, pc_cur, branch_en, branch_taken, branch_idx, halt,
               lut_we, lut_waddr, lut_wdata,
        output done, pc_next, cycle_count
    );
endinterface

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - 16-entry branch target register file, writable only during program load
module branch_lut
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  logic     we,
    input  lut_idx_t waddr,
    input  pc_t      wdata,
    input  lut_idx_t ridx,
    output pc_t      rdata
);
    pc_t entries [LUT_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (load && we) begin
            entries[waddr] <= wdata;
        end
    end

    assign rdata = entries[ridx];
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - program run sequencer, next-PC mux and run-cycle counter
// FETCH_BRANCH_REL_EN: LUT entries become signed PC-relative offsets instead of absolute targets.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    fetch_if.slave bus
);
    fetch_state_t state, state_next;
    logic         done_q;
    cyc_t         cycle_q;
    pc_t          lut_rdata;

    branch_lut u_lut (
        .clk   (clk),
        .reset (reset),
        .load  (state == LOAD),
        .we    (bus.lut_we),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .ridx  (bus.branch_idx),
        .rdata (lut_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In RUN a start request aborts the program even if halt arrives on the same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = LOAD;
            LOAD: if (!bus.start) state_next = RUN;
            RUN: begin
                if (bus.start)     state_next = LOAD;
                else if (bus.halt) state_next = DONE;
            end
            DONE: if (bus.start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q  <= 1'b0;
            cycle_q <= '0;
        end else begin
            done_q <= (state_next == DONE);
            if (state_next == LOAD) begin
                cycle_q <= '0;
            end else if (state == RUN && cycle_q != '1) begin
                cycle_q <= cycle_q + cyc_t'(1);
            end
        end
    end

    always_comb begin
        bus.pc_next = bus.pc_cur;
        if (state == RUN && !bus.halt) begin
            if (bus.branch_en && bus.branch_taken) begin
`ifdef FETCH_BRANCH_REL_EN
                bus.pc_next = bus.pc_cur + lut_rdata;
`else
                bus.pc_next = lut_rdata;
`endif
            end else begin
                bus.pc_next = bus.pc_cur + pc_t'(1);
            end
        end
    end

    assign bus.done        = done_q;
    assign bus.cycle_count = cycle_q;
endmodule
